// File: rtl/irq_pending_ctrl.sv
// Pending-request collector: latches req into pending, presents highest-index ID with valid/ready.
// Latency: req at edge k -> pending at k -> irq_valid after k+1; next ID one cycle after each ack.
// Backpressure: irq_id/irq_valid held until irq_ready; IRQ_EDGE_EN selects edge-detected req.
module irq_pending_ctrl #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic                 irq_valid,
  input  logic                 irq_ready,
  output logic [$clog2(N)-1:0] irq_id,
  output logic [N-1:0]         pending,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam int IDW = $clog2(N);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] id_q, id_d, top_idx;
  logic [N-1:0]   pending_q, pending_d, set_v, clr_v;
  logic           ovf_q, ovf_hit, ack;

`ifdef IRQ_EDGE_EN
  logic [N-1:0] req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= '0;
    else        req_q <= req;
  end

  assign set_v = req & ~req_q;
`else
  assign set_v = req;
`endif

  assign ack       = (state_q == PRESENT) & irq_ready;
  assign clr_v     = ack ? (N'(1) << id_q) : '0;
  // Set is OR-ed in after the clear, so a same-cycle set/clear leaves the bit pending.
  assign pending_d = (pending_q & ~clr_v) | set_v;
  assign ovf_hit   = |(set_v & pending_q & ~clr_v);

  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) top_idx = IDW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          id_d    = top_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      if (ovf_hit)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign irq_valid = (state_q == PRESENT);
  assign irq_id    = id_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl; inputs change and outputs are sampled 1ns after posedge.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       irq_valid;
  logic       irq_ready;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic       ovf;
  logic       ovf_clr;

  int n_assert = 0;
  int n_fail   = 0;

  irq_pending_ctrl #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .irq_valid (irq_valid),
    .irq_ready (irq_ready),
    .irq_id    (irq_id),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks valid, id and pending together after the current edge.
  task automatic chk3(input string tag, input logic v, input logic [2:0] id, input logic [7:0] p);
    check({tag, ".valid"}, 32'(irq_valid), 32'(v));
    if (v) check({tag, ".id"}, 32'(irq_id), 32'(id));
    check({tag, ".pending"}, 32'(pending), 32'(p));
  endtask

  initial begin
    rst_n = 1'b0; req = '0; irq_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    check("rst.valid", 32'(irq_valid), 32'd0);
    check("rst.id", 32'(irq_id), 32'd0);
    check("rst.pending", 32'(pending), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    step();

    // T2 single request; ready held high while valid is low must be ignored
    req = 8'h10; irq_ready = 1'b1;
    step(); chk3("t2.e1", 1'b0, 3'd0, 8'h10);
    req = 8'h00;
    step(); chk3("t2.e2", 1'b1, 3'd4, 8'h10);
    step(); chk3("t2.e3", 1'b0, 3'd0, 8'h00);

    // T3 priority drain 0x25 -> 5,2,0
    req = 8'h25;
    step(); chk3("t3.e1", 1'b0, 3'd0, 8'h25);
    req = 8'h00;
    step(); chk3("t3.e2", 1'b1, 3'd5, 8'h25);
    step(); chk3("t3.e3", 1'b0, 3'd0, 8'h05);
    step(); chk3("t3.e4", 1'b1, 3'd2, 8'h05);
    step(); chk3("t3.e5", 1'b0, 3'd0, 8'h01);
    step(); chk3("t3.e6", 1'b1, 3'd0, 8'h01);
    step(); chk3("t3.e7", 1'b0, 3'd0, 8'h00);

    // T4 backpressure: ID 2 held for 10 cycles, higher request does not preempt
    irq_ready = 1'b0; req = 8'h04;
    step();
    step(); chk3("t4.first", 1'b1, 3'd2, 8'h04);
    for (int i = 0; i < 8; i++) begin
      step(); chk3("t4.hold", 1'b1, 3'd2, 8'h04);
    end
    req = 8'h80;
    step(); chk3("t4.pre", 1'b1, 3'd2, 8'h84);
    req = 8'h00; irq_ready = 1'b1;
    step(); chk3("t4.ack2", 1'b0, 3'd0, 8'h80);
    step(); chk3("t4.id7", 1'b1, 3'd7, 8'h80);
    step(); chk3("t4.ack7", 1'b0, 3'd0, 8'h00);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t4.ovfclr", 32'(ovf), 32'd0);

    // T5 set/clear collision on bit 3
    irq_ready = 1'b0; req = 8'h08;
    step();
    req = 8'h00;
    step(); chk3("t5.pres", 1'b1, 3'd3, 8'h08);
    req = 8'h08; irq_ready = 1'b1;
    step(); chk3("t5.coll", 1'b0, 3'd0, 8'h08);
    check("t5.ovf", 32'(ovf), 32'd0);
    req = 8'h00;
    step(); chk3("t5.again", 1'b1, 3'd3, 8'h08);
    step(); chk3("t5.done", 1'b0, 3'd0, 8'h00);

    // T6 overflow: second pulse while bit 1 still pending
    irq_ready = 1'b0; req = 8'h02;
    step();
    req = 8'h00;
    step(); chk3("t6.pres", 1'b1, 3'd1, 8'h02);
    check("t6.noovf", 32'(ovf), 32'd0);
    req = 8'h02;
    step(); check("t6.ovf", 32'(ovf), 32'd1);
    req = 8'h00;
    step(); check("t6.sticky", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    step(); check("t6.clr", 32'(ovf), 32'd0);
    ovf_clr = 1'b0; irq_ready = 1'b1;
    step(); chk3("t6.ack", 1'b0, 3'd0, 8'h00);

    // Held req=0x02 with no ack: edge mode sets once, level mode flags overflow
    irq_ready = 1'b0; req = 8'h02;
    for (int i = 0; i < 4; i++) step();
`ifdef IRQ_EDGE_EN
    check("t6.held_ovf", 32'(ovf), 32'd0);
`else
    check("t6.held_ovf", 32'(ovf), 32'd1);
`endif
    chk3("t6.held", 1'b1, 3'd1, 8'h02);
    req = 8'h00; irq_ready = 1'b1; ovf_clr = 1'b1;
    step(); chk3("t6.hack", 1'b0, 3'd0, 8'h00);
    ovf_clr = 1'b0;
    check("t6.hclr", 32'(ovf), 32'd0);

    // T1 async reset mid-PRESENT with all pending
    irq_ready = 1'b0; req = 8'hFF;
    step(); chk3("t1.all", 1'b0, 3'd0, 8'hFF);
    req = 8'h00;
    step(); chk3("t1.pres", 1'b1, 3'd7, 8'hFF);
    rst_n = 1'b0;
    #1;
    check("t1.valid", 32'(irq_valid), 32'd0);
    check("t1.pending", 32'(pending), 32'd0);
    check("t1.ovf", 32'(ovf), 32'd0);
    check("t1.id", 32'(irq_id), 32'd0);
    step();
    rst_n = 1'b1;
    step(); chk3("t1.after", 1'b0, 3'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
